// File: rtl/seven_seg_scanner.sv
// Scan controller for a 4-digit common-anode display: rotates the active-low anode
// select, supplies the matching nibble, and swaps in new ALU data only at frame starts.
module seven_seg_scanner #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load,
   input  logic [7:0] y_in,
   input  logic [3:0] op_in,
   output logic [3:0] anode,
   output logic [3:0] digit_val,
   output logic       frame_tick,
   output logic       pending
);

   localparam int              CNT_W     = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_VAL = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
   logic [1:0]       idx_reg, idx_next;
   logic [7:0]       shadow_y_reg, active_y_reg;
   logic [3:0]       shadow_op_reg, active_op_reg;
   logic             pending_reg, pending_next;
   logic [3:0]       anode_reg, anode_next;
   logic [3:0]       digit_reg, digit_next;
   logic             frame_tick_reg;

   logic slot_end;
   logic frame_end;
   logic frame_start;
   logic blank;

   assign slot_end    = (div_cnt_reg == CNT_LAST);
   assign frame_end   = slot_end && (idx_reg == 2'd3);
   assign frame_start = (idx_reg == 2'd0) && (div_cnt_reg == '0);

   // Slot and digit-index counters
   always_comb begin
      div_cnt_next = div_cnt_reg + 1'b1;
      idx_next     = idx_reg;
      if (slot_end) begin
         div_cnt_next = '0;
         idx_next     = idx_reg + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_reg <= '0;
         idx_reg     <= 2'd0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         idx_reg     <= idx_next;
      end
   end

   // A load coinciding with the frame edge still commits the older shadow contents.
   always_comb begin
      pending_next = pending_reg;
      if (load)
         pending_next = 1'b1;
      else if (frame_end)
         pending_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_y_reg  <= 8'h00;
         shadow_op_reg <= 4'h0;
         active_y_reg  <= 8'h00;
         active_op_reg <= 4'h0;
         pending_reg   <= 1'b0;
      end else begin
         if (load) begin
            shadow_y_reg  <= y_in;
            shadow_op_reg <= op_in;
         end
         if (frame_end && pending_reg) begin
            active_y_reg  <= shadow_y_reg;
            active_op_reg <= shadow_op_reg;
         end
         pending_reg <= pending_next;
      end
   end

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (div_cnt_reg < BLANK_VAL);
      end
   endgenerate

   // Each anode bit is low only for its own index, so at most one digit is ever driven.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_anode
         assign anode_next[gi] = ~(en && !blank && (idx_reg == 2'(gi)));
      end
   endgenerate

   always_comb begin
      digit_next = 4'h0;
      case (idx_reg)
         2'd0:    digit_next = active_op_reg;
         2'd1:    digit_next = 4'h0;
         2'd2:    digit_next = active_y_reg[3:0];
         default: digit_next = active_y_reg[7:4];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode_reg      <= 4'b1111;
         digit_reg      <= 4'h0;
         frame_tick_reg <= 1'b0;
      end else begin
         anode_reg      <= anode_next;
         digit_reg      <= digit_next;
         frame_tick_reg <= frame_start;
      end
   end

   assign anode      = anode_reg;
   assign digit_val  = digit_reg;
   assign frame_tick = frame_tick_reg;
   assign pending    = pending_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with an 8-cycle slot and 2-cycle blanking
// (32-cycle frames); every output is checked on every cycle of each frame.
module tb_seven_seg_scanner;

   localparam int RD = 8;
   localparam int BC = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b1;
   logic       load  = 1'b0;
   logic [7:0] y_in  = 8'h00;
   logic [3:0] op_in = 4'h0;
   logic [3:0] anode;
   logic [3:0] digit_val;
   logic       frame_tick;
   logic       pending;

   int   checks   = 0;
   int   errors   = 0;
   int   fno      = 0;
   logic pend_exp = 1'b0;

   seven_seg_scanner #(
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .load      (load),
      .y_in      (y_in),
      .op_in     (op_in),
      .anode     (anode),
      .digit_val (digit_val),
      .frame_tick(frame_tick),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Runs nsteps cycles of one frame. ay/aop are the active values the frame should
   // display; l1_j/l2_j are the in-frame cycles at which a load strobe is applied.
   task automatic run_frame(input logic [7:0] ay, input logic [3:0] aop, input logic en_val,
                            input int nsteps, input int l1_j, input logic [11:0] l1_v,
                            input int l2_j, input logic [11:0] l2_v);
      logic       ld;
      int         dv;
      int         ix;
      logic [3:0] exp_an;
      logic [3:0] exp_dv;
      en = en_val;
      for (int j = 0; j < nsteps; j++) begin
         ld = (j == l1_j) || (j == l2_j);
         if (j == l1_j)
            {y_in, op_in} = l1_v;
         else if (j == l2_j)
            {y_in, op_in} = l2_v;
         load = ld;
         step();
         load = 1'b0;
         if (ld)
            pend_exp = 1'b1;
         else if (j == 31)
            pend_exp = 1'b0;
         dv = j % RD;
         ix = j / RD;
         if (!en_val || dv < BC)
            exp_an = 4'b1111;
         else
            exp_an = ~(4'b0001 << ix);
         case (ix)
            0:       exp_dv = aop;
            1:       exp_dv = 4'h0;
            2:       exp_dv = ay[3:0];
            default: exp_dv = ay[7:4];
         endcase
         chk($sformatf("anode f%0d j%0d", fno, j), {4'h0, anode}, {4'h0, exp_an});
         chk($sformatf("digit_val f%0d j%0d", fno, j), {4'h0, digit_val}, {4'h0, exp_dv});
         chk($sformatf("frame_tick f%0d j%0d", fno, j), {7'h0, frame_tick}, {7'h0, (j == 0)});
         chk($sformatf("pending f%0d j%0d", fno, j), {7'h0, pending}, {7'h0, pend_exp});
      end
      fno++;
   endtask

   initial begin
      repeat (3) step();
      chk("reset anode", {4'h0, anode}, 8'h0F);
      chk("reset digit_val", {4'h0, digit_val}, 8'h00);
      chk("reset frame_tick", {7'h0, frame_tick}, 8'h00);
      chk("reset pending", {7'h0, pending}, 8'h00);
      rst_n = 1'b1;
      chk("release anode", {4'h0, anode}, 8'h0F);

      // Idle frame, then a load during idx1 that must not show until the wrap
      run_frame(8'h00, 4'h0, 1'b1, 32, -1, 12'h000, -1, 12'h000);
      run_frame(8'h00, 4'h0, 1'b1, 32, 10, 12'h5A3, -1, 12'h000);
      // 5A/3 displayed; two loads in one frame, last one wins
      run_frame(8'h5A, 4'h3, 1'b1, 32, 3, 12'h111, 20, 12'h222);
      // 22 displayed; 44 loaded, then 77 loaded on the exact wrap edge
      run_frame(8'h22, 4'h2, 1'b1, 32, 5, 12'h444, 31, 12'h777);
      // 44 displayed with pending still high, 77 follows a frame later
      run_frame(8'h44, 4'h4, 1'b1, 32, -1, 12'h000, -1, 12'h000);
      // Display disabled for a whole frame; ticks and commits continue
      run_frame(8'h77, 4'h7, 1'b0, 32, 12, 12'h999, -1, 12'h000);
      // Re-enabled showing 99; load BB then reset part-way through idx2
      run_frame(8'h99, 4'h9, 1'b1, 21, 3, 12'hBBB, -1, 12'h000);

      chk("pre-reset anode", {4'h0, anode}, 8'h0B);
      chk("pre-reset pending", {7'h0, pending}, 8'h01);
      rst_n = 1'b0;
      #1;
      chk("async reset anode", {4'h0, anode}, 8'h0F);
      chk("async reset pending", {7'h0, pending}, 8'h00);
      chk("async reset digit_val", {4'h0, digit_val}, 8'h00);
      step();
      step();
      chk("held reset anode", {4'h0, anode}, 8'h0F);
      rst_n = 1'b1;
      pend_exp = 1'b0;

      // Restart at idx0 with blanking; the discarded BB must never appear
      run_frame(8'h00, 4'h0, 1'b1, 32, -1, 12'h000, -1, 12'h000);
      run_frame(8'h00, 4'h0, 1'b1, 32, -1, 12'h000, -1, 12'h000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
